// File: rtl/uart_duplex.sv
// Full-duplex UART: independent TX and RX state machines with configurable
// width, parity and stop bits, ready/valid handshakes and per-word error flags.
module uart_duplex #(
   parameter int CLK_DIV   = 16,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 tx,
   input  logic                 rx,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 rx_valid,
   output logic [DATA_BITS-1:0] rx_data,
   input  logic                 rx_ready,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_overrun
);

   localparam int HALF = CLK_DIV / 2;
   localparam int CW   = $clog2(STOP_BITS * CLK_DIV + 1);
   localparam int BW   = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] BIT_LAST   = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST  = CW'(HALF - 1);
   localparam logic [CW-1:0] STOP_LAST  = CW'(STOP_BITS * CLK_DIV - 1);
   localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOPS_LAST = BW'(STOP_BITS - 1);
   localparam logic          PAR_EN     = (PARITY != 0);
   localparam logic          PAR_ODD    = (PARITY == 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // Parity bit that makes data plus parity odd or even as configured
   function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
      return PAR_ODD ? ~(^d) : (^d);
   endfunction

   state_t                tx_state_q, tx_state_d;
   logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
   logic [BW-1:0]         tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
   logic                  tx_par_q, tx_par_d;
   logic                  tx_q, tx_d;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + CW'(1);
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_d       = tx_q;
      case (tx_state_q)
         S_IDLE: begin
            tx_cnt_d = '0;
            tx_d     = 1'b1;
            if (tx_valid) begin
               tx_state_d = S_START;
               tx_shift_d = tx_data;
               tx_par_d   = calc_parity(tx_data);
               tx_d       = 1'b0;
            end
         end
         S_START: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_state_d = S_DATA;
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_d       = tx_shift_q[0];
            end
         end
         S_DATA: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = '0;
               if (tx_bit_q == DATA_LAST) begin
                  if (PAR_EN) begin
                     tx_state_d = S_PARITY;
                     tx_d       = tx_par_q;
                  end else begin
                     tx_state_d = S_STOP;
                     tx_d       = 1'b1;
                  end
               end else begin
                  tx_bit_d   = tx_bit_q + BW'(1);
                  tx_shift_d = tx_shift_q >> 1;
                  tx_d       = tx_shift_q[1];
               end
            end
         end
         S_PARITY: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_state_d = S_STOP;
               tx_cnt_d   = '0;
               tx_d       = 1'b1;
            end
         end
         S_STOP: begin
            // All stop bits are timed as one long high period
            if (tx_cnt_q == STOP_LAST) begin
               tx_state_d = S_IDLE;
               tx_cnt_d   = '0;
            end
         end
         default: begin
            tx_state_d = S_IDLE;
            tx_cnt_d   = '0;
            tx_d       = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= S_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         tx_q       <= tx_d;
      end
   end

   assign tx       = tx_q;
   assign tx_ready = (tx_state_q == S_IDLE);

   // rx is asynchronous to clk; everything downstream sees only rx_s_q
   logic rx_meta_q, rx_s_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   state_t                rx_state_q, rx_state_d;
   logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
   logic [BW-1:0]         rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
   logic                  rx_par_bit_q, rx_par_bit_d;
   logic                  rx_stop_err_q, rx_stop_err_d;
   logic                  rx_valid_q, rx_valid_d;
   logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
   logic                  rx_perr_q, rx_perr_d;
   logic                  rx_ferr_q, rx_ferr_d;
   logic                  rx_ovr_q, rx_ovr_d;
   logic                  rx_done;
   logic                  rx_ferr_now;
   logic                  rx_perr_now;

   assign rx_ferr_now = rx_stop_err_q | ~rx_s_q;
   assign rx_perr_now = PAR_EN & (calc_parity(rx_shift_q) != rx_par_bit_q);

   always_comb begin
      rx_state_d    = rx_state_q;
      rx_cnt_d      = rx_cnt_q + CW'(1);
      rx_bit_d      = rx_bit_q;
      rx_shift_d    = rx_shift_q;
      rx_par_bit_d  = rx_par_bit_q;
      rx_stop_err_d = rx_stop_err_q;
      rx_valid_d    = rx_valid_q;
      rx_data_d     = rx_data_q;
      rx_perr_d     = rx_perr_q;
      rx_ferr_d     = rx_ferr_q;
      rx_ovr_d      = rx_ovr_q;
      rx_done       = 1'b0;
      case (rx_state_q)
         S_IDLE: begin
            rx_cnt_d = '0;
            if (!rx_s_q) begin
               rx_state_d = S_START;
            end
         end
         S_START: begin
            // Mid-start sample; a line already back high was only a glitch
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d      = '0;
               rx_bit_d      = '0;
               rx_stop_err_d = 1'b0;
               rx_state_d    = rx_s_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s_q, rx_shift_q[DATA_BITS-1:1]};
               if (rx_bit_q == DATA_LAST) begin
                  rx_bit_d   = '0;
                  rx_state_d = PAR_EN ? S_PARITY : S_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + BW'(1);
               end
            end
         end
         S_PARITY: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d     = '0;
               rx_bit_d     = '0;
               rx_par_bit_d = rx_s_q;
               rx_state_d   = S_STOP;
            end
         end
         S_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d      = '0;
               rx_stop_err_d = rx_ferr_now;
               if (rx_bit_q == STOPS_LAST) begin
                  rx_done    = 1'b1;
                  rx_state_d = S_IDLE;
               end else begin
                  rx_bit_d = rx_bit_q + BW'(1);
               end
            end
         end
         default: begin
            rx_state_d = S_IDLE;
            rx_cnt_d   = '0;
         end
      endcase

      // A completing frame wins over a plain consume; same-cycle consume reloads
      if (rx_done) begin
         if (!rx_valid_q || rx_ready) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shift_q;
            rx_perr_d  = rx_perr_now;
            rx_ferr_d  = rx_ferr_now;
            rx_ovr_d   = 1'b0;
         end else begin
            rx_ovr_d = 1'b1;
         end
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
         rx_perr_d  = 1'b0;
         rx_ferr_d  = 1'b0;
         rx_ovr_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_q    <= S_IDLE;
         rx_cnt_q      <= '0;
         rx_bit_q      <= '0;
         rx_shift_q    <= '0;
         rx_par_bit_q  <= 1'b0;
         rx_stop_err_q <= 1'b0;
         rx_valid_q    <= 1'b0;
         rx_data_q     <= '0;
         rx_perr_q     <= 1'b0;
         rx_ferr_q     <= 1'b0;
         rx_ovr_q      <= 1'b0;
      end else begin
         rx_state_q    <= rx_state_d;
         rx_cnt_q      <= rx_cnt_d;
         rx_bit_q      <= rx_bit_d;
         rx_shift_q    <= rx_shift_d;
         rx_par_bit_q  <= rx_par_bit_d;
         rx_stop_err_q <= rx_stop_err_d;
         rx_valid_q    <= rx_valid_d;
         rx_data_q     <= rx_data_d;
         rx_perr_q     <= rx_perr_d;
         rx_ferr_q     <= rx_ferr_d;
         rx_ovr_q      <= rx_ovr_d;
      end
   end

   assign rx_valid      = rx_valid_q;
   assign rx_data       = rx_data_q;
   assign rx_parity_err = rx_perr_q;
   assign rx_frame_err  = rx_ferr_q;
   assign rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_duplex.sv
// Directed bench for uart_duplex: three instances cover 8N1 at CLK_DIV=4,
// an 8E2 loopback at CLK_DIV=8 and a 7O1 receiver driven by hand-built frames.
module tb_uart_duplex;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   logic       tx_a, rx_a, tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a;
   logic [7:0] tx_data_a, rx_data_a;
   logic       rx_perr_a, rx_ferr_a, rx_ovr_a;

   logic       tx_b, rx_b, tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b;
   logic [7:0] tx_data_b, rx_data_b;
   logic       rx_perr_b, rx_ferr_b, rx_ovr_b;

   logic       tx_c, rx_c, tx_valid_c, tx_ready_c, rx_valid_c, rx_ready_c;
   logic [6:0] tx_data_c, rx_data_c;
   logic       rx_perr_c, rx_ferr_c, rx_ovr_c;

   assign rx_b = tx_b;

   uart_duplex #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
      .clk(clk), .rst(rst), .tx(tx_a), .rx(rx_a),
      .tx_valid(tx_valid_a), .tx_data(tx_data_a), .tx_ready(tx_ready_a),
      .rx_valid(rx_valid_a), .rx_data(rx_data_a), .rx_ready(rx_ready_a),
      .rx_parity_err(rx_perr_a), .rx_frame_err(rx_ferr_a), .rx_overrun(rx_ovr_a));

   uart_duplex #(.CLK_DIV(8), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_dut_b (
      .clk(clk), .rst(rst), .tx(tx_b), .rx(rx_b),
      .tx_valid(tx_valid_b), .tx_data(tx_data_b), .tx_ready(tx_ready_b),
      .rx_valid(rx_valid_b), .rx_data(rx_data_b), .rx_ready(rx_ready_b),
      .rx_parity_err(rx_perr_b), .rx_frame_err(rx_ferr_b), .rx_overrun(rx_ovr_b));

   uart_duplex #(.CLK_DIV(8), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_dut_c (
      .clk(clk), .rst(rst), .tx(tx_c), .rx(rx_c),
      .tx_valid(tx_valid_c), .tx_data(tx_data_c), .tx_ready(tx_ready_c),
      .rx_valid(rx_valid_c), .rx_data(rx_data_c), .rx_ready(rx_ready_c),
      .rx_parity_err(rx_perr_c), .rx_frame_err(rx_ferr_c), .rx_overrun(rx_ovr_c));

   function automatic logic [15:0] frame_8n1(input logic [7:0] d);
      return {6'b0, 1'b1, d, 1'b0};
   endfunction

   function automatic logic [15:0] frame_7o1(input logic [6:0] d, input logic par, input logic stop);
      return {6'b0, stop, par, d, 1'b0};
   endfunction

   // Called at a negedge; drives each frame bit for div cycles, then idles high
   task automatic drive_rx(input int which, input logic [15:0] bits, input int nbits, input int div);
      for (int j = 0; j < nbits; j++) begin
         if (which == 0) rx_a = bits[j];
         else rx_c = bits[j];
         repeat (div) @(negedge clk);
      end
      if (which == 0) rx_a = 1'b1;
      else rx_c = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if ({tx_a, tx_b, tx_c} !== 3'b111) begin errors++; $display("[TB] FAIL reset_tx: got %b expected 111", {tx_a, tx_b, tx_c}); end
      checks++; if ({tx_ready_a, tx_ready_b, tx_ready_c} !== 3'b111) begin errors++; $display("[TB] FAIL reset_tx_ready: got %b expected 111", {tx_ready_a, tx_ready_b, tx_ready_c}); end
      checks++; if ({rx_valid_a, rx_valid_b, rx_valid_c} !== 3'b000) begin errors++; $display("[TB] FAIL reset_rx_valid: got %b expected 000", {rx_valid_a, rx_valid_b, rx_valid_c}); end
      checks++; if ({rx_data_a, rx_data_c} !== 15'h0) begin errors++; $display("[TB] FAIL reset_rx_data: got %h expected 0", {rx_data_a, rx_data_c}); end
      checks++; if ({rx_perr_a, rx_ferr_a, rx_ovr_a, rx_perr_c, rx_ferr_c, rx_ovr_c} !== 6'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000000", {rx_perr_a, rx_ferr_a, rx_ovr_a, rx_perr_c, rx_ferr_c, rx_ovr_c}); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_tx_waveform();
      logic [9:0] fr;
      fr = {1'b1, 8'hA5, 1'b0};
      tx_valid_a = 1'b1;
      tx_data_a  = 8'hA5;
      @(negedge clk);
      tx_valid_a = 1'b0;
      tx_data_a  = 8'h00;
      for (int c = 0; c < 40; c++) begin
         checks++; if (tx_a !== fr[c / 4]) begin errors++; $display("[TB] FAIL tx_wave cycle %0d: got %b expected %b", c, tx_a, fr[c / 4]); end
         checks++; if (tx_ready_a !== 1'b0) begin errors++; $display("[TB] FAIL tx_ready_busy cycle %0d: got %b expected 0", c, tx_ready_a); end
         if (c == 5) begin tx_valid_a = 1'b1; tx_data_a = 8'hFF; end
         if (c == 30) tx_valid_a = 1'b0;
         @(negedge clk);
      end
      checks++; if (tx_ready_a !== 1'b1) begin errors++; $display("[TB] FAIL tx_ready_return: got %b expected 1", tx_ready_a); end
      checks++; if (tx_a !== 1'b1) begin errors++; $display("[TB] FAIL tx_idle_after: got %b expected 1", tx_a); end
   endtask

   task automatic test_loopback_even();
      logic [7:0] words [3];
      logic [7:0] got [3];
      logic [2:0] got_flags [3];
      logic       par_seen [3];
      logic       prev_s, prev_m;
      int         nrx, npar, sent, since;
      words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h3C;
      nrx = 0; npar = 0; sent = 0; since = 1000;
      rx_ready_b = 1'b1;
      fork
         begin
            prev_s     = tx_ready_b;
            tx_data_b  = words[0];
            tx_valid_b = 1'b1;
            for (int c = 0; c < 400 && sent < 3; c++) begin
               @(negedge clk);
               if (prev_s && !tx_ready_b) begin
                  sent++;
                  if (sent < 3) tx_data_b = words[sent];
                  else tx_valid_b = 1'b0;
               end
               prev_s = tx_ready_b;
            end
            tx_valid_b = 1'b0;
         end
         begin
            prev_m = tx_ready_b;
            for (int c = 0; c < 500; c++) begin
               @(negedge clk);
               if (prev_m && !tx_ready_b) since = 0;
               else since++;
               prev_m = tx_ready_b;
               if (since == 76 && npar < 3) begin par_seen[npar] = tx_b; npar++; end
               if (rx_valid_b) begin
                  if (nrx < 3) begin got[nrx] = rx_data_b; got_flags[nrx] = {rx_perr_b, rx_ferr_b, rx_ovr_b}; end
                  nrx++;
               end
            end
         end
      join
      checks++; if (sent !== 3) begin errors++; $display("[TB] FAIL loop_sent: got %0d expected 3", sent); end
      checks++; if (nrx !== 3) begin errors++; $display("[TB] FAIL loop_rx_count: got %0d expected 3", nrx); end
      checks++; if (npar !== 3) begin errors++; $display("[TB] FAIL loop_par_count: got %0d expected 3", npar); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (got[i] !== words[i]) begin errors++; $display("[TB] FAIL loop_data %0d: got %h expected %h", i, got[i], words[i]); end
         checks++; if (got_flags[i] !== 3'b000) begin errors++; $display("[TB] FAIL loop_flags %0d: got %b expected 000", i, got_flags[i]); end
         checks++; if (par_seen[i] !== 1'b0) begin errors++; $display("[TB] FAIL loop_par_bit %0d: got %b expected 0", i, par_seen[i]); end
      end
   endtask

   task automatic test_error_frames();
      rx_ready_c = 1'b0;
      drive_rx(1, frame_7o1(7'h55, 1'b0, 1'b1), 10, 8);
      checks++; if (rx_valid_c !== 1'b1) begin errors++; $display("[TB] FAIL perr_valid: got %b expected 1", rx_valid_c); end
      checks++; if (rx_data_c !== 7'h55) begin errors++; $display("[TB] FAIL perr_data: got %h expected 55", rx_data_c); end
      checks++; if ({rx_perr_c, rx_ferr_c, rx_ovr_c} !== 3'b100) begin errors++; $display("[TB] FAIL perr_flags: got %b expected 100", {rx_perr_c, rx_ferr_c, rx_ovr_c}); end
      rx_ready_c = 1'b1;
      @(negedge clk);
      rx_ready_c = 1'b0;
      checks++; if ({rx_valid_c, rx_perr_c, rx_ferr_c, rx_ovr_c} !== 4'b0000) begin errors++; $display("[TB] FAIL perr_consume: got %b expected 0000", {rx_valid_c, rx_perr_c, rx_ferr_c, rx_ovr_c}); end
      drive_rx(1, frame_7o1(7'h2A, 1'b0, 1'b0), 10, 8);
      checks++; if (rx_valid_c !== 1'b1) begin errors++; $display("[TB] FAIL ferr_valid: got %b expected 1", rx_valid_c); end
      checks++; if (rx_data_c !== 7'h2A) begin errors++; $display("[TB] FAIL ferr_data: got %h expected 2a", rx_data_c); end
      checks++; if ({rx_perr_c, rx_ferr_c, rx_ovr_c} !== 3'b010) begin errors++; $display("[TB] FAIL ferr_flags: got %b expected 010", {rx_perr_c, rx_ferr_c, rx_ovr_c}); end
      repeat (20) @(negedge clk);
      checks++; if ({rx_valid_c, rx_ovr_c} !== 2'b10) begin errors++; $display("[TB] FAIL ferr_tail: got %b expected 10", {rx_valid_c, rx_ovr_c}); end
      rx_ready_c = 1'b1;
      @(negedge clk);
      rx_ready_c = 1'b0;
      checks++; if ({rx_valid_c, rx_ferr_c} !== 2'b00) begin errors++; $display("[TB] FAIL ferr_consume: got %b expected 00", {rx_valid_c, rx_ferr_c}); end
   endtask

   task automatic test_overrun();
      rx_ready_c = 1'b0;
      drive_rx(1, frame_7o1(7'h11, 1'b1, 1'b1), 10, 8);
      checks++; if ({rx_valid_c, rx_ovr_c} !== 2'b10) begin errors++; $display("[TB] FAIL ovr_first: got %b expected 10", {rx_valid_c, rx_ovr_c}); end
      drive_rx(1, frame_7o1(7'h22, 1'b1, 1'b1), 10, 8);
      checks++; if (rx_data_c !== 7'h11) begin errors++; $display("[TB] FAIL ovr_data: got %h expected 11", rx_data_c); end
      checks++; if ({rx_valid_c, rx_perr_c, rx_ferr_c, rx_ovr_c} !== 4'b1001) begin errors++; $display("[TB] FAIL ovr_flags: got %b expected 1001", {rx_valid_c, rx_perr_c, rx_ferr_c, rx_ovr_c}); end
      rx_ready_c = 1'b1;
      @(negedge clk);
      rx_ready_c = 1'b0;
      checks++; if ({rx_valid_c, rx_perr_c, rx_ferr_c, rx_ovr_c} !== 4'b0000) begin errors++; $display("[TB] FAIL ovr_consume: got %b expected 0000", {rx_valid_c, rx_perr_c, rx_ferr_c, rx_ovr_c}); end
   endtask

   task automatic test_glitch();
      rx_ready_a = 1'b0;
      rx_a = 1'b0;
      @(negedge clk);
      rx_a = 1'b1;
      repeat (30) @(negedge clk);
      checks++; if (rx_valid_a !== 1'b0) begin errors++; $display("[TB] FAIL glitch_valid: got %b expected 0", rx_valid_a); end
      drive_rx(0, frame_8n1(8'h81), 10, 4);
      checks++; if (rx_valid_a !== 1'b0) begin errors++; $display("[TB] FAIL glitch_early: got %b expected 0", rx_valid_a); end
      @(negedge clk);
      checks++; if (rx_valid_a !== 1'b1) begin errors++; $display("[TB] FAIL glitch_latency: got %b expected 1", rx_valid_a); end
      checks++; if (rx_data_a !== 8'h81) begin errors++; $display("[TB] FAIL glitch_data: got %h expected 81", rx_data_a); end
      checks++; if ({rx_perr_a, rx_ferr_a, rx_ovr_a} !== 3'b000) begin errors++; $display("[TB] FAIL glitch_flags: got %b expected 000", {rx_perr_a, rx_ferr_a, rx_ovr_a}); end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] rbits;
      rbits = frame_8n1(8'h3C);
      checks++; if (rx_valid_a !== 1'b1) begin errors++; $display("[TB] FAIL midrst_held: got %b expected 1", rx_valid_a); end
      for (int m = 0; m < 26; m++) begin
         rx_a = rbits[m / 4];
         if (m == 8) begin tx_valid_a = 1'b1; tx_data_a = 8'h52; end
         if (m == 9) tx_valid_a = 1'b0;
         if (m == 25) begin
            checks++; if (tx_a !== 1'b0) begin errors++; $display("[TB] FAIL midrst_tx_bit3: got %b expected 0", tx_a); end
            rst = 1'b1;
         end
         @(negedge clk);
      end
      checks++; if ({tx_a, tx_ready_a} !== 2'b11) begin errors++; $display("[TB] FAIL midrst_tx: got %b expected 11", {tx_a, tx_ready_a}); end
      checks++; if (rx_valid_a !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rx_valid: got %b expected 0", rx_valid_a); end
      checks++; if (rx_data_a !== 8'h00) begin errors++; $display("[TB] FAIL midrst_rx_data: got %h expected 00", rx_data_a); end
      rst  = 1'b0;
      rx_a = 1'b1;
      repeat (5) @(negedge clk);
      drive_rx(0, frame_8n1(8'hC3), 10, 4);
      @(negedge clk);
      checks++; if (rx_valid_a !== 1'b1) begin errors++; $display("[TB] FAIL midrst_after_valid: got %b expected 1", rx_valid_a); end
      checks++; if (rx_data_a !== 8'hC3) begin errors++; $display("[TB] FAIL midrst_after_data: got %h expected c3", rx_data_a); end
      checks++; if ({rx_perr_a, rx_ferr_a, rx_ovr_a} !== 3'b000) begin errors++; $display("[TB] FAIL midrst_after_flags: got %b expected 000", {rx_perr_a, rx_ferr_a, rx_ovr_a}); end
   endtask

   initial begin
      rx_a = 1'b1; tx_valid_a = 1'b0; tx_data_a = '0; rx_ready_a = 1'b0;
      tx_valid_b = 1'b0; tx_data_b = '0; rx_ready_b = 1'b0;
      rx_c = 1'b1; tx_valid_c = 1'b0; tx_data_c = '0; rx_ready_c = 1'b0;
      test_reset();
      test_tx_waveform();
      test_loopback_even();
      test_error_frames();
      test_overrun();
      test_glitch();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not complete within 200000 time units");
      $fatal(1, "[TB] timeout");
   end

endmodule
